fork_dataless: RTL
==================

# fork_dataless

Eager fork for dataless (control-only) handshake channels. It replicates each incoming token to `SIZE` consumers. Each consumer may accept the token in a different cycle, and the input is released only after every consumer has received its copy. It sits directly upstream of `elastic_fifo_inner_dataless` instances and other control-token consumers, where a single control token must start several parallel branches.

## Interface
Parameters:
- `SIZE`, default 2: number of output branches. Legal range is ≥ 1.

Ports:
- `clk`, input, 1: clock. All state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Assertion (`rst` = 0) clears state immediately, independent of `clk`.
- `ins_valid`, input, 1: upstream token present.
- `ins_ready`, output, 1: fork consumes the upstream token this cycle.
- `outs_valid`, output, `SIZE`: bit i means branch i is offered a token.
- `outs_ready`, input, `SIZE`: bit i means branch i accepts.

## Operation
State:
- One flop per branch, `sent[i]`. Value 1 means branch i has already taken the current token.

Combinational outputs:
- `outs_valid[i] = ins_valid & ~sent[i]`.
  - Must not depend on any `outs_ready` bit, so no ready→valid combinational path exists.
- `ins_ready = AND over i of (sent[i] | outs_ready[i])`.
- A transfer on branch i: `xfer[i] = outs_valid[i] & outs_ready[i]`.
- Token consumed: `done = ins_valid & ins_ready`.

Next state on each rising edge, while `rst` = 1:
- If `done`: all `sent[i]` ← 0, ready for the next token.
- Otherwise: `sent[i]` ← `sent[i] | xfer[i]`.

Per-branch state machine:
- IDLE (`sent` = 0) → SENT (`sent` = 1) on `xfer[i] & ~done`.
- SENT → IDLE on `done`.
- IDLE stays IDLE on `done`, since the branch transferred in the same cycle the token completed.

Reset:
- While `rst` = 0: all `sent[i]` = 0.
- Outputs during reset: `outs_valid` = `{SIZE{ins_valid}}` and `ins_ready` = `&outs_ready`. These are combinational; no output is registered.
- Reset asserted mid-token discards partial delivery. After release, the still-valid upstream token is offered again to all branches, and branches that already took it receive a duplicate. The system-level reset contract accepts this.

Boundary conditions:
- All branches ready in the same cycle: token passes with zero latency, `done` = 1, and `sent` stays all-zero.
- Upstream drops `ins_valid` while some `sent[i]` = 1: this is a protocol violation upstream. `sent` holds its value; no requirement applies.
- `SIZE` = 1: degenerates to a wire, `ins_ready = outs_ready[0]` and `outs_valid[0] = ins_valid`. `sent[0]` never becomes 1, because `xfer` implies `done`.

## Timing
- Latency is 0 cycles: a token is visible on `outs_valid` in the same cycle as `ins_valid`.
- Throughput is 1 token/cycle when all branches are ready.
- A branch stalled for N cycles holds the input for N cycles. Branches that already received the token see `outs_valid[i]` = 0 during the stall.
- Back-to-back tokens: the cycle after `done`, all `outs_valid` bits again follow `ins_valid`.
- Combinational paths:
  - `ins_valid` → `outs_valid`.
  - `outs_ready` → `ins_ready`.
  - No `outs_ready` → `outs_valid` path.

## Test plan
All scenarios use `SIZE` = 3.
- Reset, then `ins_valid`=1 with `outs_ready`=111 for 4 cycles → `outs_valid`=111 and `ins_ready`=1 every cycle; `sent` stays 000; 4 tokens are counted on each branch.
- `ins_valid`=1 held; `outs_ready`=001 in cycle 0, 010 in cycle 1, 100 in cycle 2:
  - `outs_valid` = 111 in cycle 0, 110 in cycle 1, 100 in cycle 2.
  - `ins_ready` = 1 only in cycle 2.
  - Cycle 3 shows `outs_valid`=111 for the next token.
- `outs_ready[2]` held at 0 for 5 cycles while bits 0 and 1 are 1 → branches 0 and 1 each receive exactly 1 transfer; `ins_ready`=0 for all 5 cycles; the token completes in the cycle `outs_ready[2]` rises.
- Partial delivery (`sent`=011), then `rst` pulsed low mid-cycle (asynchronously) → `sent` = 000 immediately; after release, `outs_valid`=111.
- Random `ins_valid`/`outs_ready` over 10k cycles; each branch feeds an `elastic_fifo_inner_dataless` with `NUM_SLOTS`=4 and random drain:
  - Per-branch token counts equal the upstream consumed count (±1 in-flight).
  - No `outs_valid[i]` drop without a transfer while `ins_valid` is held.

Source files
------------

// File: rtl/fork_dataless.sv
// Eager fork for dataless handshake channels: replicates each upstream token to SIZE
// branches, releasing the input only once every branch has taken its copy.
module fork_dataless #(
  parameter int unsigned SIZE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ins_valid,
  output logic            ins_ready,
  output logic [SIZE-1:0] outs_valid,
  input  logic [SIZE-1:0] outs_ready
);

  logic [SIZE-1:0] sent_q;
  logic [SIZE-1:0] sent_d;
  logic [SIZE-1:0] xfer;
  logic            done;

  always_comb begin
    // outs_valid is built from state only so there is no ready->valid path
    outs_valid = {SIZE{ins_valid}} & ~sent_q;
    ins_ready  = &(sent_q | outs_ready);
    xfer       = outs_valid & outs_ready;
    done       = ins_valid & ins_ready;
    sent_d     = done ? '0 : (sent_q | xfer);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule
